// File: rtl/vga_cell_render_if.sv
// CPU-side bus of vga_cell_render: cell writes, swap request and swap status.
// cpu_rdata exists only when VGA_CELL_READBACK_EN is defined.
interface vga_cell_render_if;
    logic       cpu_we;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_swap;
    logic       swap_pend;
    logic       frame_swp;
`ifdef VGA_CELL_READBACK_EN
    logic [7:0] cpu_rdata;

    modport slave  (input  cpu_we, cpu_addr, cpu_wdata, cpu_swap,
                    output swap_pend, frame_swp, cpu_rdata);
    modport master (output cpu_we, cpu_addr, cpu_wdata, cpu_swap,
                    input  swap_pend, frame_swp, cpu_rdata);
`else
    modport slave  (input  cpu_we, cpu_addr, cpu_wdata, cpu_swap,
                    output swap_pend, frame_swp);
    modport master (output cpu_we, cpu_addr, cpu_wdata, cpu_swap,
                    input  swap_pend, frame_swp);
`endif
endinterface

// File: rtl/vga_cell_render.sv
// Game-of-Life cell renderer: double-buffered cell RAM, 2-cycle pixel pipeline,
// tear-free bank swap at VS start. Optional macro: VGA_CELL_READBACK_EN (cpu_rdata).
module vga_cell_render #(
    parameter logic [2:0] ALIVE_RGB = 3'b010,
    parameter logic [2:0] DEAD_RGB  = 3'b000,
    parameter int         DEPTH     = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     vga_HS_in,
    input  logic                     vga_VS_in,
    input  logic                     vga_DA_in,
    input  logic [7:0]               vaddr,
    vga_cell_render_if.slave         cpu,
    output logic                     vga_HS,
    output logic                     vga_VS,
    output logic                     vga_DA,
    output logic [2:0]               vga_RGB
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, PEND} state_t;

    logic [7:0] mem_q [0:1][0:DEPTH-1];
    logic [7:0] byte_q;
    logic       hs_d1_q, vs_d1_q, da_d1_q;
    logic       hs_q, vs_q, da_q;
    logic [2:0] rgb_q, rgb_d;
    logic       vs_prev_q, vs_fall;
    state_t     state_q, state_d;
    logic       front_q, front_d;
    logic       frame_swp_q, frame_swp_d;
    logic       unused_vaddr_msb;

    assign unused_vaddr_msb = vaddr[7];

    // Back bank is the one not displayed; front is never written.
    always_ff @(posedge clk) begin
        if (cpu.cpu_we && cpu.cpu_addr[7])
            mem_q[~front_q][cpu.cpu_addr[AW-1:0]] <= cpu.cpu_wdata;
    end

    always_ff @(posedge clk) begin
        byte_q <= mem_q[front_q][vaddr[AW-1:0]];
    end

    assign rgb_d = da_d1_q ? ((byte_q != 8'h00) ? ALIVE_RGB : DEAD_RGB) : 3'b000;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_d1_q <= 1'b1;
            vs_d1_q <= 1'b1;
            da_d1_q <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            da_q    <= 1'b0;
            rgb_q   <= 3'b000;
        end else begin
            hs_d1_q <= vga_HS_in;
            vs_d1_q <= vga_VS_in;
            da_d1_q <= vga_DA_in;
            hs_q    <= hs_d1_q;
            vs_q    <= vs_d1_q;
            da_q    <= da_d1_q;
            rgb_q   <= rgb_d;
        end
    end

    assign vga_HS  = hs_q;
    assign vga_VS  = vs_q;
    assign vga_DA  = da_q;
    assign vga_RGB = rgb_q;

    assign vs_fall = vs_prev_q & ~vga_VS_in;

    // A request arriving together with the VS fall is taken immediately.
    always_comb begin
        state_d     = state_q;
        front_d     = front_q;
        frame_swp_d = 1'b0;
        if (vs_fall && (state_q == PEND || cpu.cpu_swap)) begin
            state_d     = IDLE;
            front_d     = ~front_q;
            frame_swp_d = 1'b1;
        end else if (cpu.cpu_swap) begin
            state_d = PEND;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            front_q     <= 1'b0;
            frame_swp_q <= 1'b0;
            vs_prev_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            front_q     <= front_d;
            frame_swp_q <= frame_swp_d;
            vs_prev_q   <= vga_VS_in;
        end
    end

    assign cpu.swap_pend = (state_q == PEND);
    assign cpu.frame_swp = frame_swp_q;

`ifdef VGA_CELL_READBACK_EN
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) rdata_q <= 8'h00;
        else        rdata_q <= mem_q[~front_q][cpu.cpu_addr[AW-1:0]];
    end

    assign cpu.cpu_rdata = rdata_q;
`endif
endmodule

// File: tb/tb_vga_cell_render.sv
module tb_vga_cell_render;
    localparam logic [2:0] ALIVE = 3'b010;
    localparam logic [2:0] DEAD  = 3'b000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hs_in, vs_in, da_in;
    logic [7:0] vaddr;
    logic       vga_HS, vga_VS, vga_DA;
    logic [2:0] vga_RGB;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;

    typedef struct {
        int         due;
        int         kind;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb_q[$];

    vga_cell_render_if bus();

    vga_cell_render dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .vga_HS_in (hs_in),
        .vga_VS_in (vs_in),
        .vga_DA_in (da_in),
        .vaddr     (vaddr),
        .cpu       (bus),
        .vga_HS    (vga_HS),
        .vga_VS    (vga_VS),
        .vga_DA    (vga_DA),
        .vga_RGB   (vga_RGB)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] actual(int kind);
        logic [7:0] a;
        a = 8'h00;
        case (kind)
            0: a = {2'b00, vga_HS, vga_VS, vga_DA, vga_RGB};
            1: a = {7'b0, bus.swap_pend};
            2: a = {7'b0, bus.frame_swp};
`ifdef VGA_CELL_READBACK_EN
            3: a = bus.cpu_rdata;
`endif
            default: a = 8'hxx;
        endcase
        return a;
    endfunction

    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].due <= cyc) begin
                checks++;
                if (sb_q[i].due < cyc || actual(sb_q[i].kind) !== sb_q[i].exp) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%h expected=%h", sb_q[i].name, cyc,
                             actual(sb_q[i].kind), sb_q[i].exp);
                end
                sb_q.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expv(int lat, logic hs, logic vs, logic da, logic [2:0] rgb, string nm);
        exp_t e;
        e.due = cyc + lat; e.kind = 0; e.exp = {2'b00, hs, vs, da, rgb}; e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic exps(int lat, int kind, logic [7:0] v, string nm);
        exp_t e;
        e.due = cyc + lat; e.kind = kind; e.exp = v; e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic idle_in();
        hs_in = 1'b1; vs_in = 1'b1; da_in = 1'b0; vaddr = 8'h80;
        bus.cpu_we = 1'b0; bus.cpu_addr = 8'h80; bus.cpu_wdata = 8'h00; bus.cpu_swap = 1'b0;
    endtask

    task automatic clear_back();
        for (int i = 0; i < 128; i++) begin
            bus.cpu_we = 1'b1; bus.cpu_addr = 8'h80 | 8'(i); bus.cpu_wdata = 8'h00;
            step();
        end
        bus.cpu_we = 1'b0;
    endtask

    initial begin
        logic h, v, d;
        rst_n = 1'b0;
        idle_in();
        repeat (3) step();
        checks++;
        if (vga_HS !== 1'b1 || vga_VS !== 1'b1 || vga_DA !== 1'b0 || vga_RGB !== 3'b000) begin
            errors++;
            $display("FAIL rst_out_direct HS=%b VS=%b DA=%b RGB=%b", vga_HS, vga_VS, vga_DA, vga_RGB);
        end
        checks++;
        if (bus.swap_pend !== 1'b0) begin
            errors++;
            $display("FAIL rst_pend_direct got=%b", bus.swap_pend);
        end
        expv(1, 1, 1, 0, 3'b000, "rst_vga");
        exps(1, 1, 8'h00, "rst_pend");
        exps(1, 2, 8'h00, "rst_fswp");
`ifdef VGA_CELL_READBACK_EN
        exps(1, 3, 8'h00, "rst_rdata");
`endif
        step();
        rst_n = 1'b1;

        clear_back();
        bus.cpu_swap = 1'b1; step();
        bus.cpu_swap = 1'b0; vs_in = 1'b0; step();
        vs_in = 1'b1; step();
        clear_back();
        step();

        bus.cpu_we = 1'b1; bus.cpu_addr = 8'h81; bus.cpu_wdata = 8'h01; step();
        bus.cpu_addr = 8'h05; bus.cpu_wdata = 8'hFF;
        da_in = 1'b1; vaddr = 8'h81;
        expv(2, 1, 1, 1, DEAD, "wr_noswap");
        step();
        bus.cpu_we = 1'b0; da_in = 1'b0;
        expv(2, 1, 1, 0, 3'b000, "da_low");
        step();

        bus.cpu_swap = 1'b1;
        exps(1, 1, 8'h01, "pend_set");
        exps(1, 2, 8'h00, "no_swp_yet");
        step();
        checks++;
        if (bus.swap_pend !== 1'b1) begin
            errors++;
            $display("FAIL pend_set_direct got=%b", bus.swap_pend);
        end
        bus.cpu_swap = 1'b0; step();
        bus.cpu_swap = 1'b1;
        exps(1, 1, 8'h01, "pend_hold");
        step();
        bus.cpu_swap = 1'b0; vs_in = 1'b0; da_in = 1'b1; vaddr = 8'h81;
        exps(1, 2, 8'h01, "fswp");
        exps(1, 1, 8'h00, "pend_clr");
        expv(2, 1, 0, 1, DEAD, "rd_preswap");
        step();
        checks++;
        if (bus.frame_swp !== 1'b1 || bus.swap_pend !== 1'b0) begin
            errors++;
            $display("FAIL fswp_direct fswp=%b pend=%b", bus.frame_swp, bus.swap_pend);
        end
        vs_in = 1'b1;
        exps(1, 2, 8'h00, "fswp_pulse");
        expv(2, 1, 1, 1, ALIVE, "rd_postswap");
        step();
        checks++;
        if (bus.frame_swp !== 1'b0) begin
            errors++;
            $display("FAIL fswp_pulse_direct got=%b", bus.frame_swp);
        end
        vaddr = 8'h85;
        expv(2, 1, 1, 1, DEAD, "lo_addr_ign");
        step();
        da_in = 1'b0; vaddr = 8'h81;
        expv(2, 1, 1, 0, 3'b000, "rgb_da0");
        step();

        bus.cpu_swap = 1'b1; vs_in = 1'b0;
        bus.cpu_we = 1'b1; bus.cpu_addr = 8'h90; bus.cpu_wdata = 8'h33;
        exps(1, 2, 8'h01, "sim_fswp");
        exps(1, 1, 8'h00, "sim_pend");
        step();
        bus.cpu_swap = 1'b0; bus.cpu_we = 1'b0; vs_in = 1'b1; da_in = 1'b1; vaddr = 8'h90;
        expv(2, 1, 1, 1, ALIVE, "sim_wr_vis");
        step();
        vaddr = 8'h81;
        expv(2, 1, 1, 1, DEAD, "old_front_gone");
        step();
        da_in = 1'b0; step();

        vaddr = 8'h90;
        for (int i = 0; i < 24; i++) begin
            h = 1'($urandom_range(0, 1)); v = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1));
            hs_in = h; vs_in = v; da_in = d;
            expv(2, h, v, d, d ? ALIVE : 3'b000, "align");
            step();
        end
        idle_in();
        step(); step();

        bus.cpu_swap = 1'b1; step();
        bus.cpu_swap = 1'b0; rst_n = 1'b0; da_in = 1'b1; hs_in = 1'b0; vaddr = 8'h90;
        expv(1, 1, 1, 0, 3'b000, "midrst_vga");
        exps(1, 1, 8'h00, "midrst_pend");
        step();
        rst_n = 1'b1; hs_in = 1'b1; vaddr = 8'h81;
        expv(1, 1, 1, 0, 3'b000, "rel_flush");
        expv(2, 1, 1, 1, ALIVE, "rel_first");
        step();
        da_in = 1'b0; step();

`ifdef VGA_CELL_READBACK_EN
        bus.cpu_we = 1'b1; bus.cpu_addr = 8'hA5; bus.cpu_wdata = 8'h07;
        exps(1, 3, 8'h00, "rb_old");
        step();
        bus.cpu_we = 1'b0;
        exps(1, 3, 8'h07, "rb_new");
        step();
`endif

        repeat (4) step();
        foreach (sb_q[i]) begin
            checks++;
            errors++;
            $display("FAIL %s never compared due=%0d", sb_q[i].name, sb_q[i].due);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
